// File: rtl/gba_io_pkg.sv
// Shared gba_io definitions: arbiter FSM states, grant-owner codes, bus widths.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Owner codes match the frame buffer's occupier codes. The buffer decodes
// from_cart/from_usb with the same values, so these encodings must not change.
package gba_io_pkg;

  localparam int GBA_ADDR_W = 26;  // memory word-address width
  localparam int GBA_DATA_W = 16;  // memory data width

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_RD = 2'd2,
    DONE    = 2'd3
  } arb_state_t;

  typedef enum logic [1:0] {
    NONE = 2'b00,
    CART = 2'b01,
    USB  = 2'b10
  } owner_t;

  // Grant decision for one IDLE cycle. The cart is the latency-critical
  // requester and normally wins. Once the USB side has been passed over
  // USB_MAX_WAIT times in a row (usb_starved), the USB request takes the
  // next grant instead.
  function automatic owner_t arb_pick(input logic cart_req,
                                      input logic usb_req,
                                      input logic usb_starved);
    owner_t pick;
    pick = NONE;
    if (cart_req && (!usb_req || !usb_starved)) begin
      pick = CART;
    end else if (usb_req) begin
      pick = USB;
    end
    return pick;
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Two-requester (cart, usb) arbiter in front of a single-command memory port.
// Latency: request seen in IDLE -> mem_req next cycle -> ack one cycle after accept (writes), +1 per read-wait cycle.
// Backpressure: command held stable while mem_ready=0; requesters are blocked (no ack) until the single outstanding access completes.
//
// Ports:
//   clk, rst                          rising-edge clock, synchronous active-high reset
//   cart_req/we/addr/wdata            cart command in (sampled only in IDLE)
//   cart_ack, cart_rdata              one-cycle completion pulse, read data (holds between reads)
//   usb_*                             same meanings for the USB requester
//   mem_req/we/addr/wdata             memory command out, held until mem_ready
//   mem_ready, mem_rvalid, mem_rdata  command accept, read return strobe and data
//   from_cart, from_usb               current grant owner (one-hot while busy, 0 in IDLE)
module mem_arbiter
  import gba_io_pkg::*;
#(
  parameter int ADDR_W       = GBA_ADDR_W,
  parameter int DATA_W       = GBA_DATA_W,
  parameter int USB_MAX_WAIT = 8
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              cart_req,
  input  logic              cart_we,
  input  logic [ADDR_W-1:0] cart_addr,
  input  logic [DATA_W-1:0] cart_wdata,
  output logic              cart_ack,
  output logic [DATA_W-1:0] cart_rdata,

  input  logic              usb_req,
  input  logic              usb_we,
  input  logic [ADDR_W-1:0] usb_addr,
  input  logic [DATA_W-1:0] usb_wdata,
  output logic              usb_ack,
  output logic [DATA_W-1:0] usb_rdata,

  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,

  output logic              from_cart,
  output logic              from_usb
);

  // A zero wait limit would give a zero-width counter; keep at least one bit.
  localparam int CNT_W = (USB_MAX_WAIT < 1) ? 1 : $clog2(USB_MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(USB_MAX_WAIT);

  arb_state_t       state_q;
  arb_state_t       state_d;
  owner_t           owner_q;
  owner_t           pick;
  owner_t           grant;
  logic [CNT_W-1:0] starve_cnt;

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next state and control outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    grant    = NONE;
    mem_req  = 1'b0;
    cart_ack = 1'b0;
    usb_ack  = 1'b0;
    pick     = arb_pick(cart_req, usb_req, starve_cnt >= CNT_MAX);

    case (state_q)
      IDLE: begin
        // Requesters drop req on the edge that samples their ack, so a
        // request still high here is always a new one.
        grant = pick;
        if (pick != NONE) begin
          state_d = ISSUE;
        end
      end

      ISSUE: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          state_d = mem_we ? DONE : WAIT_RD;
        end
      end

      WAIT_RD: begin
        if (mem_rvalid) begin
          state_d = DONE;
        end
      end

      DONE: begin
        cart_ack = (owner_q == CART);
        usb_ack  = (owner_q == USB);
        state_d  = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Latched command, owner, starvation counter and read-data registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q    <= NONE;
      starve_cnt <= '0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      cart_rdata <= '0;
      usb_rdata  <= '0;
    end else begin
      case (grant)
        CART: begin
          owner_q   <= CART;
          mem_we    <= cart_we;
          mem_addr  <= cart_addr;
          mem_wdata <= cart_wdata;
          // Only grants that actually pass over a waiting USB request count.
          if (usb_req && (starve_cnt != CNT_MAX)) begin
            starve_cnt <= starve_cnt + CNT_W'(1);
          end
        end
        USB: begin
          owner_q    <= USB;
          mem_we     <= usb_we;
          mem_addr   <= usb_addr;
          mem_wdata  <= usb_wdata;
          starve_cnt <= '0;
        end
        default: begin
        end
      endcase

      // Read return is only meaningful while waiting for it; a stray or
      // late strobe in any other state (e.g. after a reset) is dropped.
      if ((state_q == WAIT_RD) && mem_rvalid) begin
        if (owner_q == CART) begin
          cart_rdata <= mem_rdata;
        end else if (owner_q == USB) begin
          usb_rdata <= mem_rdata;
        end
      end

      // Ownership ends with the ack cycle so IDLE always shows no owner.
      if (state_q == DONE) begin
        owner_q <= NONE;
      end
    end
  end

  assign from_cart = (owner_q == CART);
  assign from_usb  = (owner_q == USB);

endmodule
